// File: rtl/ram_access_arbiter.sv
// Purpose : round-robin (or fixed-priority) arbiter sharing one single-port RAM among NUM_REQ clients.
// Latency : req sampled at cycle k -> RAM strobe at k+1 -> done pulse at k+3 -> next arbitration at k+4.
// Backpres: no skid or queue; a requester holds req until granted, and the grant is held for the whole transaction.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   req/req_we          per-requester level request and op (1=write, 0=read)
//   req_addr/req_wdata  flattened per-requester address / write data (slot i at [i*W +: W])
//   gnt/done            one-hot grant (whole transaction) and one-cycle completion pulse
//   rdata               read data, valid in the done cycle of a read, held between reads
//   busy                high whenever the arbiter is not idle
//   mem_*               RAM command port (registered-read RAM, 1-cycle read latency)
//
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins,
// pointer held at 0). Default build is round-robin.

module ram_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_n;

  // Arbitration bookkeeping
  logic [IDX_W-1:0]   ptr;        // round-robin start index
  logic [IDX_W-1:0]   win_q;      // latched winner of the current transaction
  logic               op_we;      // latched op of the current transaction

  // Combinational arbitration results (only consumed in IDLE)
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;       // one extra bit so ptr+k never overflows before the wrap
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] cur_onehot;

  // ------------------------------------------------------------------
  // Winner search: first set req bit at or after ptr, wrapping at
  // NUM_REQ-1 -> 0. The wrap is an explicit subtract so that a
  // non-power-of-two NUM_REQ never lands on an unused index. In the
  // fixed-priority build ptr is pinned to 0, so the same scan yields
  // the lowest requesting index.
  // ------------------------------------------------------------------
  always_comb begin : arbitrate
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Mux out the winner's command fields and build one-hot vectors.
  always_comb begin : select_fields
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    win_onehot = '0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_we        = req_we[i];
        sel_addr      = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata     = req_wdata[i*DATA_W +: DATA_W];
        win_onehot[i] = 1'b1;
      end
      if (win_q == IDX_W'(i)) begin
        cur_onehot[i] = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and RAM strobes. Strobes are decoded from state so
  // they drop on the same edge that a reset forces the FSM to IDLE, and
  // read/write are mutually exclusive by construction.
  // ------------------------------------------------------------------
  always_comb begin : fsm_next
    state_n   = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = CMD;
        end
      end
      CMD: begin
        mem_write = op_we;
        mem_read  = !op_we;
        state_n   = WAIT;
      end
      WAIT: begin
        state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // ------------------------------------------------------------------
  // Datapath: grant/command latch, read capture, done pulse, pointer.
  // mem_addr/mem_wdata keep their latched value until the next grant.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      ptr       <= '0;
      win_q     <= '0;
      op_we     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt       <= win_onehot;
            win_q     <= win_idx;
            op_we     <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        WAIT: begin
          // RAM registered output is valid now; writes leave rdata alone.
          if (!op_we) begin
            rdata <= mem_rdata;
          end
          done <= cur_onehot;
        end
        DONE: begin
          gnt  <= '0;
          done <= '0;
`ifdef RAM_ARB_FIXED_PRIO_EN
          ptr  <= '0;
`else
          if (win_q == IDX_W'(NUM_REQ-1)) begin
            ptr <= '0;
          end else begin
            ptr <= win_q + 1'b1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
`timescale 1ns/1ps
module tb_ram_access_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic            mem_read;
  logic            mem_write;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  ram_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro: synchronous write, registered read.
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata     <= ram[mem_addr];
  end

  // ---------------- transaction-level reference model ----------------
  // m_age: 0 = no transaction, else number of edges since the grant edge.
  logic [DW-1:0] ref_mem [16];
  int            m_age = 0;
  int            m_win = 0;
  int            m_ptr = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd_pending = '0;
  logic [DW-1:0] m_rdata = '0;

  task automatic model_edge();
    if (!reset) begin
      m_age   = 0;
      m_ptr   = 0;
      m_rdata = '0;
    end else if (m_age == 0) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_win = (m_ptr + k) % N;
            break;
          end
        end
        m_we    = req_we[m_win];
        m_addr  = req_addr[m_win*AW +: AW];
        m_wdata = req_wdata[m_win*DW +: DW];
        // Once granted, a write always lands in the RAM (even if reset follows).
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_rd_pending    = ref_mem[m_addr];
        m_age = 1;
      end
    end else if (m_age < 3) begin
      m_age++;
      if (m_age == 3 && !m_we) m_rdata = m_rd_pending;
    end else begin
      m_age = 0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      m_ptr = (m_win + 1) % N;
`endif
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] oh;
    oh = '0;
    if (m_age != 0) oh[m_win] = 1'b1;
    check("gnt",       32'(gnt),       32'(oh));
    check("done",      32'(done),      (m_age == 3) ? 32'(oh) : 32'd0);
    check("busy",      32'(busy),      32'(m_age != 0));
    check("mem_write", 32'(mem_write), 32'(m_age == 1 && m_we));
    check("mem_read",  32'(mem_read),  32'(m_age == 1 && !m_we));
    check("rdata",     32'(rdata),     32'(m_rdata));
    check("rw_excl",   32'(mem_read & mem_write), 32'd0);
    if (m_age == 1) begin
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_we) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
  endtask

  // One clock: model follows the edge, outputs are checked 1ns later,
  // after which the caller may change inputs for the next edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]               = we;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  logic [N-1:0] rr_exp [5];
  int           wr_cnt;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
`ifdef RAM_ARB_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    reset = 1'b0; req = '1; req_we = '0; req_addr = '0; req_wdata = '0;

    // Reset held with all requests up
    cycle(); cycle();
    check("rst_gnt",  32'(gnt),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    cycle();
    check("first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    repeat (3) cycle();

    // Requester 2 writes A7 to 5, then reads it back
    drive(2, 1'b1, 4'h5, 8'hA7); req = 4'b0100;
    cycle(); req = '0;
    wr_cnt = int'(mem_write);
    check("wr_addr",  32'(mem_addr),  32'h5);
    check("wr_wdata", 32'(mem_wdata), 32'hA7);
    cycle(); wr_cnt += int'(mem_write);
    cycle(); wr_cnt += int'(mem_write);
    check("wr_done2", 32'(done), 32'b0100);
    check("wr_pulses", 32'(wr_cnt), 32'd1);
    cycle();
    drive(2, 1'b0, 4'h5, 8'h00); req = 4'b0100;
    cycle(); req = '0;
    cycle(); cycle();
    check("rd_done2", 32'(done),  32'b0100);
    check("rd_A7",    32'(rdata), 32'hA7);
    cycle();

    // All requesting continuously
    reset_pulse();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      cycle();
      check("rr_gnt", 32'(gnt), 32'(rr_exp[t]));
      repeat (3) cycle();
    end
    req = '0;

    // Wrap and skip: grant 2 alone, then 0 and 2 together
    reset_pulse();
    req = 4'b0100;
    cycle(); req = '0;
    repeat (3) cycle();
    req = 4'b0101;
    cycle();
    check("wrap_gnt0", 32'(gnt), 32'b0001);
    repeat (3) cycle();
    cycle();
`ifdef RAM_ARB_FIXED_PRIO_EN
    check("skip_gnt", 32'(gnt), 32'b0001);
`else
    check("skip_gnt", 32'(gnt), 32'b0100);
`endif
    req = '0;
    repeat (3) cycle();

    // Reset during CMD of a write to 9
    drive(0, 1'b1, 4'h9, 8'h5A); req = 4'b0001;
    cycle();
    reset = 1'b0; req = '0;
    cycle();
    check("abort_gnt",  32'(gnt),       32'd0);
    check("abort_wr",   32'(mem_write), 32'd0);
    check("abort_done", 32'(done),      32'd0);
    reset = 1'b1;
    cycle();
    check("abort_busy", 32'(busy), 32'd0);
    req = 4'b1001;   // a non-zero pointer would favour requester 3
    cycle();
    check("abort_ptr0", 32'(gnt), 32'b0001);
    req = '0;
    repeat (3) cycle();
    drive(3, 1'b0, 4'h9, 8'h00); req = 4'b1000;
    cycle(); req = '0;
    cycle(); cycle();
    check("abort_wr_kept", 32'(rdata), 32'h5A);
    cycle();

    // Early drop: requester 1 reads 3 and drops req in CMD
    drive(0, 1'b1, 4'h3, 8'h3C); req = 4'b0001;
    cycle(); req = '0;
    repeat (3) cycle();
    drive(1, 1'b0, 4'h3, 8'h00); req = 4'b0010;
    cycle();
    req = '0;
    cycle(); cycle();
    check("drop_done1", 32'(done),  32'b0010);
    check("drop_3C",    32'(rdata), 32'h3C);
    cycle();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      req_we    = N'($urandom);
      req_addr  = (N*AW)'($urandom);
      req_wdata = (N*DW)'($urandom);
      req       = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      reset     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1; req = '0;
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
